// File: rtl/lfsr_stats_pkg.sv
// Shared types and helpers for the LFSR Hamming-distance statistics stage.
package lfsr_stats_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_e;

  // Patterns up to 64 bits wide are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_seq_div.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first, CNT_W iterations.
module lfsr_seq_div #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] quotient,
  output logic [CNT_W-1:0] remainder
);

  localparam int unsigned IterW = $clog2(CNT_W + 1);
  localparam logic [IterW-1:0] IterLast = IterW'(CNT_W - 1);
  localparam logic [IterW-1:0] IterOne  = IterW'(1);

  logic             busy_q;
  logic [IterW-1:0] iter_q;
  logic [CNT_W-1:0] quo_q, rem_q, dvs_q;

  logic [CNT_W:0]   rem_shift, rem_diff;
  logic             ge;
  logic [CNT_W-1:0] quo_d, rem_d;

  always_comb begin
    rem_shift = {rem_q, quo_q[CNT_W-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    ge        = rem_shift >= {1'b0, dvs_q};
    rem_d     = ge ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
    quo_d     = {quo_q[CNT_W-2:0], ge};
  end

  // done flags the cycle whose iteration is the last; results are the next-state values.
  assign done      = busy_q && (iter_q == IterLast);
  assign busy      = busy_q;
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      iter_q <= iter_q + IterOne;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_hd_stats.sv
// Hamming-distance statistics, period detection and average for an LFSR pattern stream.
// Optional histogram enabled by defining LFSR_HD_STATS_HIST_EN.
module lfsr_hd_stats
  import lfsr_stats_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef LFSR_HD_STATS_HIST_EN
  input  logic [$clog2(WIDTH+1)-1:0] hist_sel,
  output logic [CNT_W-1:0]           hist_cnt,
`endif
  input  logic                       pat_valid,
  input  logic [WIDTH-1:0]           pat,
  input  logic                       clear,
  input  logic                       avg_req,
  output logic                       busy,
  output logic                       avg_valid,
  output logic [CNT_W-1:0]           avg_q,
  output logic [CNT_W-1:0]           avg_r,
  output logic                       div_zero,
  output logic [$clog2(WIDTH+1)-1:0] last_hd,
  output logic [CNT_W-1:0]           sum_hd,
  output logic [CNT_W-1:0]           n_pairs,
  output logic                       sat,
  output logic [CNT_W-1:0]           period,
  output logic                       period_valid
);

  localparam int unsigned HD_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic             first_q, sat_q, per_valid_q, per_dead_q;
  logic             avg_valid_q, div_zero_q;
  logic [WIDTH-1:0] prev_q, seed_q;
  logic [HD_W-1:0]  last_hd_q;
  logic [CNT_W-1:0] sum_q, npairs_q, per_cnt_q, period_q, avg_q_q, avg_r_q;

  logic [HD_W-1:0]  hd;
  logic [CNT_W:0]   sum_ext;
  logic             sum_sat, np_sat;
  logic [CNT_W-1:0] sum_next, np_next;
  logic             div_start, div_busy, div_done;
  logic [CNT_W-1:0] div_quo, div_rem;

  always_comb begin
    hd       = HD_W'(popcount(64'(pat ^ prev_q)));
    sum_ext  = {1'b0, sum_q} + {{(CNT_W + 1 - HD_W){1'b0}}, hd};
    sum_sat  = sum_ext >= {1'b0, CntMax};
    sum_next = sum_sat ? CntMax : sum_ext[CNT_W-1:0];
    np_sat   = npairs_q >= (CntMax - CntOne);
    np_next  = np_sat ? CntMax : npairs_q + CntOne;
  end

  assign div_start = (state_q == StIdle) && avg_req && (npairs_q != '0);

  lfsr_seq_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst || clear),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (npairs_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= StIdle;
      first_q     <= 1'b1;
      prev_q      <= '0;
      seed_q      <= '0;
      last_hd_q   <= '0;
      sum_q       <= '0;
      npairs_q    <= '0;
      sat_q       <= 1'b0;
      per_cnt_q   <= '0;
      period_q    <= '0;
      per_valid_q <= 1'b0;
      per_dead_q  <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_q_q     <= '0;
      avg_r_q     <= '0;
      div_zero_q  <= 1'b0;
      // A pattern arriving with clear seeds the new run.
      if (!rst && pat_valid) begin
        first_q   <= 1'b0;
        prev_q    <= pat;
        seed_q    <= pat;
        per_cnt_q <= CntOne;
      end
    end else begin
      if (pat_valid) begin
        prev_q <= pat;
        if (first_q) begin
          first_q   <= 1'b0;
          seed_q    <= pat;
          per_cnt_q <= CntOne;
        end else begin
          last_hd_q <= hd;
          sum_q     <= sum_next;
          npairs_q  <= np_next;
          if (sum_sat || np_sat) sat_q <= 1'b1;
          if (!per_valid_q && !per_dead_q) begin
            if (pat == seed_q) begin
              period_q    <= per_cnt_q;
              per_valid_q <= 1'b1;
            end else if (per_cnt_q == CntMax) begin
              per_dead_q <= 1'b1;
            end else begin
              per_cnt_q <= per_cnt_q + CntOne;
            end
          end
        end
      end

      avg_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (avg_req) begin
            if (npairs_q == '0) begin
              state_q     <= StDone;
              avg_q_q     <= '0;
              avg_r_q     <= '0;
              div_zero_q  <= 1'b1;
              avg_valid_q <= 1'b1;
            end else begin
              state_q    <= StDiv;
              div_zero_q <= 1'b0;
            end
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q     <= StDone;
            avg_q_q     <= div_quo;
            avg_r_q     <= div_rem;
            avg_valid_q <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LFSR_HD_STATS_HIST_EN
  logic [CNT_W-1:0] hist_q [WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i <= int'(WIDTH); i++) hist_q[i] <= '0;
      hist_cnt <= '0;
    end else begin
      if (pat_valid && !first_q && (hist_q[hd] != CntMax)) hist_q[hd] <= hist_q[hd] + CntOne;
      hist_cnt <= (32'(hist_sel) > WIDTH) ? '0 : hist_q[hist_sel];
    end
  end
`endif

  assign busy         = div_busy;
  assign avg_valid    = avg_valid_q;
  assign avg_q        = avg_q_q;
  assign avg_r        = avg_r_q;
  assign div_zero     = div_zero_q;
  assign last_hd      = last_hd_q;
  assign sum_hd       = sum_q;
  assign n_pairs      = npairs_q;
  assign sat          = sat_q;
  assign period       = period_q;
  assign period_valid = per_valid_q;

endmodule

// File: doc/lfsr_hd_stats.md
Name: lfsr_hd_stats

Overview:
- Downstream consumer of the 8-bit LFSR pattern stream produced by the PRPG core.
- Per accepted pattern, computes the Hamming distance (HD) to the previous pattern and keeps a running HD sum and pair count.
- Detects the sequence period, meaning recurrence of the first pattern.
- On request, computes the average HD with a multi-cycle sequential divider.
- Replaces the ad-hoc combinational HD/average logic with a clocked, deterministic statistics stage.

Parameters:
- WIDTH, 8, pattern width in bits.
- CNT_W, 16, width of the sum, pair-count, period and divider datapaths.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- pat_valid  in  1  pattern present this cycle.
- pat  in  WIDTH  LFSR pattern, bit-for-bit as produced by the core.
- clear  in  1  synchronous restart of all statistics.
- avg_req  in  1  start average computation (ignored when busy).
- busy  out  1  divider active.
- avg_valid  out  1  one-cycle pulse; avg_q and avg_r valid.
- avg_q  out  CNT_W  floor(sum_hd / n_pairs).
- avg_r  out  CNT_W  remainder.
- div_zero  out  1  last average requested with n_pairs == 0.
- last_hd  out  $clog2(WIDTH+1)  HD of most recent pair.
- sum_hd  out  CNT_W  running HD sum.
- n_pairs  out  CNT_W  number of pairs accumulated.
- sat  out  1  sticky: sum_hd or n_pairs saturated.
- period  out  CNT_W  patterns between seed and its recurrence.
- period_valid  out  1  sticky once the period has been found.

Behaviour:
- Reset (rst=1 at clk edge): every output is 0, state = IDLE, first-pattern flag set. rst overrides all other inputs.
- clear: same effect as rst on the statistics registers and the FSM, with the same-cycle rule below.
- First accepted pattern after reset/clear:
  - stored as prev and as seed.
  - period counter set to 1.
  - no HD produced; last_hd, sum_hd and n_pairs unchanged.
- Each later accepted pattern, registered with 1-cycle latency (visible the cycle after pat_valid):
  - last_hd = popcount(pat ^ prev).
  - sum_hd += last_hd; n_pairs += 1.
  - prev = pat.
  - Both counters saturate at all-ones. The first saturation sets sat, which stays set until clear/rst.
- Period detection:
  - the counter increments per accepted pattern while period_valid = 0.
  - when pat == seed (not the first pattern), period = counter value before increment, and period_valid goes to 1.
  - the counter freezes after detection.
  - if the counter saturates without a match, period stays 0 and the counter freezes.
- clear and pat_valid in the same cycle: clear wins, and pat becomes the new first pattern (seed/prev).
- FSM states: IDLE, DIV, DONE.
  - IDLE: on avg_req, snapshot sum_hd and n_pairs, then:
    - if snapshot n == 0: go to DONE with avg_q = 0, avg_r = 0, div_zero = 1.
    - otherwise go to DIV with iteration count 0, busy = 1, div_zero = 0.
  - DIV: one restoring-division iteration (one quotient bit, MSB first) per cycle for exactly CNT_W cycles, then DONE.
  - DONE: avg_valid = 1 for one cycle; avg_q and avg_r updated and held until the next DONE; busy = 0; return to IDLE.
- Latency: for n > 0, avg_valid is high in cycle CNT_W+1 after the avg_req sampling cycle; for n = 0, in cycle 1.
- Accumulation continues during DIV. The result reflects the snapshot only.
- avg_req while busy or in DONE is ignored (not queued).
- clear or rst during DIV/DONE aborts to IDLE: no avg_valid, avg_q and avg_r cleared.

Optional Feature:
- Macro: LFSR_HD_STATS_HIST_EN.
- Defined:
  - adds inputs hist_sel ($clog2(WIDTH+1) bits) and output hist_cnt (CNT_W bits).
  - keeps WIDTH+1 saturating counters, one per HD value 0..WIDTH, each incremented alongside sum_hd.
  - hist_cnt = counter[hist_sel], registered, 1-cycle read latency.
  - hist_sel > WIDTH returns 0.
  - counters cleared by rst/clear.
- Undefined: no histogram ports or logic; all other behaviour identical.

Decomposition:
- Package lfsr_stats_pkg holds:
  - state enum {IDLE, DIV, DONE}.
  - the popcount function.
  - default-width localparams.
- Sub-module lfsr_seq_div: start/dividend/divisor in; busy/done/quotient/remainder out; CNT_W iterations.
- The top level owns accumulation, period logic and the FSM handshake.

Test Plan:
- Reset and first pattern:
  - reset, then pat 0x00 then 0xFF → after 0x00: n_pairs = 0, sum_hd = 0.
  - after 0xFF: last_hd = 8, sum_hd = 8, n_pairs = 1.
- Average:
  - pats 0x00, 0xFF, 0xFF, 0x0F, then avg_req → sum_hd = 12, n_pairs = 3.
  - avg_valid exactly 17 cycles after req (CNT_W = 16), avg_q = 4, avg_r = 0, busy high 16 cycles.
- Zero pairs and ignored requests:
  - avg_req with n_pairs = 0 → avg_valid next cycle, avg_q = 0, div_zero = 1.
  - second avg_req during busy → no extra avg_valid.
- Period detection:
  - feed a maximal 8-bit LFSR sequence from seed 0xCC for 256 patterns → period_valid with period = 255.
  - period stays frozen on further patterns.
- Clear collisions:
  - clear mid-DIV → busy drops next cycle, no avg_valid, stats zero.
  - clear together with pat_valid = 1, pat = 0x5A → 0x5A is the new seed, n_pairs = 0.
- Saturation:
  - CNT_W = 4 build, 3 × alternating 0x00/0xFF pairs → sum_hd = 15, sat = 1 after the second pair, sum_hd stays 15.
